// File: rtl/reparam_sampler.sv
// reparam_sampler
//   VAE reparameterisation stage: z = mu + sigma * eps, all values 16-bit
//   sign-magnitude Q4.11 (bit15 sign, 0x0800 = 1.0). eps is taken from an
//   internal LFSR-based approximate Gaussian or from eps_ext when
//   eps_bypass=1. Three-stage pipeline that advances only when ready_in=1.
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   valid_in, ready_out input handshake (ready_out mirrors ready_in)
//   mu_in, sigma_in     mean and std-dev (sigma sign bit ignored)
//   eps_bypass, eps_ext external epsilon select / value
//   ready_in            downstream ready; low freezes the whole block
//   valid_out, z_out    output handshake and sample
module reparam_sampler #(
    parameter int          BITSIZE   = 16,
    parameter int          FRAC_BITS = 11,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic [BITSIZE-1:0] mu_in,
    input  logic [BITSIZE-1:0] sigma_in,
    input  logic               eps_bypass,
    input  logic [BITSIZE-1:0] eps_ext,
    input  logic               ready_in,
    output logic               valid_out,
    output logic [BITSIZE-1:0] z_out
);

    logic               accept;
    logic               lfsr_fb;
    logic [5:0]         nib_sum;
    logic [15:0]        eps_lfsr;
    logic [15:0]        eps_sel;
    logic [31:0]        prod;
    logic [31:0]        prod_shift;
    logic signed [16:0] mu_tc;
    logic signed [16:0] p_tc;
    logic signed [16:0] sum_tc;
    logic [15:0]        z_comb;
    logic               psign_comb;
    logic [14:0]        pmag_comb;

    logic [15:0] lfsr_d,     lfsr_q;
    logic [2:0]  vld_pipe_d, vld_pipe_q;   // [0]=S1, [1]=S2, [2]=S3
    logic [15:0] mu1_d,      mu1_q;
    logic [15:0] sig1_d,     sig1_q;
    logic [15:0] eps1_d,     eps1_q;
    logic [15:0] mu2_d,      mu2_q;
    logic        psign2_d,   psign2_q;
    logic [14:0] pmag2_d,    pmag2_q;
    logic [15:0] z3_d,       z3_q;

    always_comb begin
        accept = valid_in & ready_in;

        // Sum of four uniform nibbles, centred on 30, scaled by 256:
        // a cheap bell-shaped eps in -3.75..+3.75.
        nib_sum = {2'b00, lfsr_q[15:12]} + {2'b00, lfsr_q[11:8]}
                + {2'b00, lfsr_q[7:4]}   + {2'b00, lfsr_q[3:0]};
        if (nib_sum >= 6'd30)
            eps_lfsr = {1'b0, 1'b0, nib_sum - 6'd30, 8'h00};
        else
            eps_lfsr = {1'b1, 1'b0, 6'd30 - nib_sum, 8'h00};

        eps_sel = eps_bypass ? eps_ext : eps_lfsr;

        // Fibonacci taps 16,14,13,11; a nonzero seed never reaches zero.
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = accept ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;

        // S2: magnitude product, truncated and saturated.
        prod       = sig1_q * {1'b0, eps1_q[14:0]};
        prod_shift = prod >> FRAC_BITS;
        if (prod_shift > 32'h0000_7FFF)
            pmag_comb = 15'h7FFF;
        else
            pmag_comb = 15'(prod_shift);
        psign_comb = (pmag_comb != 15'd0) ? eps1_q[15] : 1'b0;

        // S3: two's-complement add; -0 inputs collapse to 0 here.
        mu_tc = $signed({2'b00, mu2_q[14:0]});
        if (mu2_q[15])
            mu_tc = -mu_tc;
        p_tc = $signed({2'b00, pmag2_q});
        if (psign2_q)
            p_tc = -p_tc;
        sum_tc = mu_tc + p_tc;
        if (sum_tc > 17'sd32767)
            z_comb = {1'b0, 15'h7FFF};
        else if (sum_tc < -17'sd32767)
            z_comb = {1'b1, 15'h7FFF};
        else if (sum_tc < 0)
            z_comb = {1'b1, 15'(-sum_tc)};
        else
            z_comb = {1'b0, 15'(sum_tc)};

        // Hold everything unless downstream is ready.
        vld_pipe_d = vld_pipe_q;
        mu1_d      = mu1_q;
        sig1_d     = sig1_q;
        eps1_d     = eps1_q;
        mu2_d      = mu2_q;
        psign2_d   = psign2_q;
        pmag2_d    = pmag2_q;
        z3_d       = z3_q;
        if (ready_in) begin
            vld_pipe_d = {vld_pipe_q[1:0], valid_in};
            mu1_d      = mu_in;
            sig1_d     = sigma_in & 16'h7FFF;
            eps1_d     = eps_sel;
            mu2_d      = mu1_q;
            psign2_d   = psign_comb;
            pmag2_d    = pmag_comb;
            z3_d       = z_comb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q     <= LFSR_SEED;
            vld_pipe_q <= 3'b000;
            mu1_q      <= 16'h0000;
            sig1_q     <= 16'h0000;
            eps1_q     <= 16'h0000;
            mu2_q      <= 16'h0000;
            psign2_q   <= 1'b0;
            pmag2_q    <= 15'h0000;
            z3_q       <= 16'h0000;
        end else begin
            lfsr_q     <= lfsr_d;
            vld_pipe_q <= vld_pipe_d;
            mu1_q      <= mu1_d;
            sig1_q     <= sig1_d;
            eps1_q     <= eps1_d;
            mu2_q      <= mu2_d;
            psign2_q   <= psign2_d;
            pmag2_q    <= pmag2_d;
            z3_q       <= z3_d;
        end
    end

    assign ready_out = ready_in;
    assign valid_out = vld_pipe_q[2];
    assign z_out     = z3_q;

endmodule
